// File: rtl/r3_pkg.sv
// rtl/r3_pkg.sv - shared constants and complex sample type for the radix-3 butterfly
package r3_pkg;

  localparam int                 CPLX_W    = 32;
  localparam logic signed [15:0] K_SQRT3_2 = 16'sd28378;
  localparam int                 K_FRAC    = 15;
  localparam int                 ROUND_C   = 1 << (K_FRAC - 1);

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] img;
  } cplx_t;

endpackage

// File: rtl/r3_sat.sv
// rtl/r3_sat.sv - clamp a DATA_W+3 signed value to DATA_W and flag the clamp
module r3_sat #(
  parameter int DATA_W = 32
) (
  input  logic signed [DATA_W+2:0] val_i,
  output logic signed [DATA_W-1:0] sat_o,
  output logic                     clamp_o
);

  localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  // In range only when the top four bits are pure sign extension.
  always_comb begin
    clamp_o = 1'b0;
    sat_o   = val_i[DATA_W-1:0];
    if (val_i[DATA_W+2:DATA_W-1] != {4{val_i[DATA_W+2]}}) begin
      clamp_o = 1'b1;
      sat_o   = val_i[DATA_W+2] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/r3_bfly_pipe.sv
// rtl/r3_bfly_pipe.sv - 3-cycle radix-3 DFT butterfly with frame tracking; R3_SCALE_EN scales results by 1/4
module r3_bfly_pipe
  import r3_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_img,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_img,
  input  logic signed [DATA_W-1:0] c_re,
  input  logic signed [DATA_W-1:0] c_img,
  output logic                     out_valid,
  output logic                     out_last,
  output logic signed [DATA_W-1:0] x0_re,
  output logic signed [DATA_W-1:0] x0_img,
  output logic signed [DATA_W-1:0] x1_re,
  output logic signed [DATA_W-1:0] x1_img,
  output logic signed [DATA_W-1:0] x2_re,
  output logic signed [DATA_W-1:0] x2_img,
  output logic                     sat_flag
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int PW    = DATA_W + 17;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_in;
  logic             v0_q, l0_q, v1_q, l1_q, v2_q, l2_q;
  logic             out_valid_q, out_last_q, sat_q;

  logic signed [DATA_W-1:0] a_re_q, a_img_q, b_re_q, b_img_q, c_re_q, c_img_q;
  logic signed [DATA_W:0]   s_re_q, s_img_q, d_re_q, d_img_q;
  logic signed [DATA_W:0]   s_re_d, s_img_d, d_re_d, d_img_d;
  logic signed [DATA_W-1:0] a1_re_q, a1_img_q;
  logic signed [DATA_W+1:0] p_re_q, p_img_q, t_re_q, t_img_q, m_re_q, m_img_q;
  logic signed [DATA_W+1:0] p_re_d, p_img_d, t_re_d, t_img_d, m_re_d, m_img_d;
  logic signed [DATA_W+2:0] res [6];
  logic signed [DATA_W-1:0] sat_v [6];
  logic signed [DATA_W-1:0] x_q [6];
  logic [5:0]               clamp;

  function automatic logic signed [DATA_W+2:0] scale(input logic signed [DATA_W+2:0] v);
`ifdef R3_SCALE_EN
    return v >>> 2;
`else
    return v;
`endif
  endfunction

  always_comb begin
    cnt_d   = cnt_q;
    last_in = in_valid && (cnt_q == CNT_W'(FRAME_LEN - 1));
    if (in_valid) cnt_d = last_in ? '0 : cnt_q + CNT_W'(1);
  end

  always_comb begin
    s_re_d  = (DATA_W+1)'(b_re_q)  + (DATA_W+1)'(c_re_q);
    s_img_d = (DATA_W+1)'(b_img_q) + (DATA_W+1)'(c_img_q);
    d_re_d  = (DATA_W+1)'(b_re_q)  - (DATA_W+1)'(c_re_q);
    d_img_d = (DATA_W+1)'(b_img_q) - (DATA_W+1)'(c_img_q);
  end

  // Twiddle term d*sqrt(3)/2 in Q1.15, rounded half-up before the shift.
  always_comb begin
    p_re_d  = (DATA_W+2)'(a1_re_q)  + (DATA_W+2)'(s_re_q);
    p_img_d = (DATA_W+2)'(a1_img_q) + (DATA_W+2)'(s_img_q);
    t_re_d  = (DATA_W+2)'(a1_re_q)  - (DATA_W+2)'(s_re_q >>> 1);
    t_img_d = (DATA_W+2)'(a1_img_q) - (DATA_W+2)'(s_img_q >>> 1);
    m_re_d  = (DATA_W+2)'((PW'(d_re_q)  * PW'(K_SQRT3_2) + PW'(ROUND_C)) >>> K_FRAC);
    m_img_d = (DATA_W+2)'((PW'(d_img_q) * PW'(K_SQRT3_2) + PW'(ROUND_C)) >>> K_FRAC);
  end

  always_comb begin
    res[0] = scale((DATA_W+3)'(p_re_q));
    res[1] = scale((DATA_W+3)'(p_img_q));
    res[2] = scale((DATA_W+3)'(t_re_q)  + (DATA_W+3)'(m_img_q));
    res[3] = scale((DATA_W+3)'(t_img_q) - (DATA_W+3)'(m_re_q));
    res[4] = scale((DATA_W+3)'(t_re_q)  - (DATA_W+3)'(m_img_q));
    res[5] = scale((DATA_W+3)'(t_img_q) + (DATA_W+3)'(m_re_q));
  end

  for (genvar g = 0; g < 6; g++) begin : g_sat
    r3_sat #(.DATA_W(DATA_W)) u_sat (
      .val_i   (res[g]),
      .sat_o   (sat_v[g]),
      .clamp_o (clamp[g])
    );
  end

  always_ff @(posedge clk) begin
    a_re_q   <= a_re;
    a_img_q  <= a_img;
    b_re_q   <= b_re;
    b_img_q  <= b_img;
    c_re_q   <= c_re;
    c_img_q  <= c_img;
    s_re_q   <= s_re_d;
    s_img_q  <= s_img_d;
    d_re_q   <= d_re_d;
    d_img_q  <= d_img_d;
    a1_re_q  <= a_re_q;
    a1_img_q <= a_img_q;
    p_re_q   <= p_re_d;
    p_img_q  <= p_img_d;
    t_re_q   <= t_re_d;
    t_img_q  <= t_img_d;
    m_re_q   <= m_re_d;
    m_img_q  <= m_img_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      v0_q        <= 1'b0;
      l0_q        <= 1'b0;
      v1_q        <= 1'b0;
      l1_q        <= 1'b0;
      v2_q        <= 1'b0;
      l2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      sat_q       <= 1'b0;
      for (int i = 0; i < 6; i++) x_q[i] <= '0;
    end else begin
      cnt_q       <= cnt_d;
      v0_q        <= in_valid;
      l0_q        <= last_in;
      v1_q        <= v0_q;
      l1_q        <= l0_q;
      v2_q        <= v1_q;
      l2_q        <= l1_q;
      out_valid_q <= v2_q;
      out_last_q  <= v2_q && l2_q;
      if (v2_q) begin
        for (int i = 0; i < 6; i++) x_q[i] <= sat_v[i];
        if (|clamp) sat_q <= 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign sat_flag  = sat_q;
  assign x0_re     = x_q[0];
  assign x0_img    = x_q[1];
  assign x1_re     = x_q[2];
  assign x1_img    = x_q[3];
  assign x2_re     = x_q[4];
  assign x2_img    = x_q[5];

endmodule

// File: doc/r3_bfly_pipe.md
Name: r3_bfly_pipe

Overview:
- Radix-3 butterfly stage that consumes the three time-aligned complex taps of a radix-3 FFT stage: x[n], x[n+D] and x[n+2D].
- The two later taps arrive through the team's 9-cycle complex delay buffers, so D=9 and N=27 for the first stage.
- Computes the 3-point DFT (X0, X1, X2) in a fixed 3-cycle pipeline.
- Tracks frame position and saturates outputs to the input width.
- Output feeds the twiddle multiplier of the next stage.

Parameters:
- DATA_W, 32: signed two's-complement width of each re/img component, in and out.
- FRAME_LEN, 9: number of valid butterflies per frame (N/3); out_last marks the final one.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  a/b/c operands valid this cycle
- a_re, a_img  in  DATA_W each  tap x[n]
- b_re, b_img  in  DATA_W each  tap x[n+D]
- c_re, c_img  in  DATA_W each  tap x[n+2D]
- out_valid  out  1  X outputs valid
- out_last  out  1  last butterfly of frame; qualified by out_valid
- x0_re, x0_img, x1_re, x1_img, x2_re, x2_img  out  DATA_W each  DFT outputs
- sat_flag  out  1  sticky: any output component saturated since reset

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid, out_last, sat_flag, all x* outputs, the valid/last pipeline and the frame counter go to 0. Internal data registers need no reset.
- No backpressure. The pipeline advances every cycle; in_valid bubbles propagate as out_valid=0.
- Latency: in_valid sampled at edge k produces out_valid=1 after edge k+3.
- Stage 1 (width DATA_W+1): s = b+c; d = b-c; a is delayed one cycle.
- Stage 2 (width DATA_W+2):
  - p = a+s.
  - t = a - (s>>>1), arithmetic shift, floor.
  - m = d*K, with K = 28378 (Q1.15 √3/2). Round by adding 2^14, then >>>15. Applied separately to re and img.
- Stage 3 (combinational with the output register):
  - X0 = p.
  - X1_re = t_re + m_img; X1_img = t_img - m_re.
  - X2_re = t_re - m_img; X2_img = t_img + m_re.
- Saturation: each stage-3 result is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Any clamp on a valid output sets sat_flag, which holds until reset.
- x* output registers load only when the stage-3 valid is 1; otherwise they hold their last value.
- Frame counter: 0..FRAME_LEN-1, increments on each accepted in_valid, wraps to 0.
  - A last bit is set when the counter equals FRAME_LEN-1 and travels with valid through the pipeline to out_last.
  - out_last=1 only when out_valid=1.
- Gaps in in_valid do not reset or advance the counter.
- Reset mid-frame: in-flight results are discarded (out_valid=0 from reset) and the counter restarts at 0.

Optional Feature:
- Macro: R3_SCALE_EN.
- Defined: each stage-3 result is arithmetic-shifted right by 2 (floor) before the saturation check. The gain of 3 then cannot overflow, so sat_flag stays 0.
- Undefined: no scaling; results are saturated as above.

Decomposition:
- Package r3_pkg holds:
  - K_SQRT3_2 = 16'sd28378 and K_FRAC = 15
  - the rounding constant 2^14
  - a complex-sample struct {re, img} sized by DATA_W
- Sub-module r3_sat: saturates a DATA_W+3 signed value to DATA_W and reports a clamp flag. It is instantiated 6 times.

Test Plan:
- a=100+0j, b=c=0, one in_valid pulse → 3 cycles later out_valid=1; X0=X1=X2=100+0j; sat_flag=0.
- a=0, b=1000+0j, c=0 → X0=1000+0j, X1=-500-866j, X2=-500+866j.
- a=b=c=0x7FFFFFFF, macro undefined → x0_re=0x7FFFFFFF and sat_flag=1. With R3_SCALE_EN: x0_re=1610612735, sat_flag=0.
- 9 valid inputs with 2 idle cycles after the 4th → 9 out_valid pulses; out_last=1 only on the 9th. The 10th input starts a new frame, so out_last fires again on the 18th.
- rst_n pulsed low mid-frame with 2 results in flight → out_valid=0 immediately and no stale outputs appear. The next frame's out_last comes on its 9th input.
- Back-to-back inputs on every cycle, compared against a complex-double reference model → results match within ±1 LSB; output rate is one per cycle.
